// File: rtl/shift_frame_pkg.sv
// Shared types and sizing helpers for the shift_frame_ctrl serial frame engine.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Legal configuration: at least two bits per frame, at least one clock per bit.
  function automatic bit params_legal(input int n, input int div);
    return (n >= 2) && (div >= 1);
  endfunction

endpackage

// File: rtl/shift_frame_ctrl_core.sv
// N-bit right-shift register: parallel load (priority) or shift with serial-in at the MSB.
module shift_reg_core
  import shift_frame_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  input  logic         si,
  output logic [N-1:0] shreg,
  output logic         so
);

  logic [N-1:0] shreg_q;
  logic [N-1:0] shreg_d;

  // Next register contents: load wins over shift, otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      shreg_d = {si, shreg_q[N-1:1]};
    end
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign shreg = shreg_q;
  assign so    = shreg_q[0];

endmodule

// File: rtl/shift_frame_ctrl.sv
// Full-duplex serial frame engine: loads a parallel word, shifts it out LSB-first
// while shifting si in at the MSB, then presents the received word for one cycle.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic         abort,
  input  logic         si,
  output logic         so,
  output logic         shift_stb,
  output logic         frame,
  output logic [N-1:0] rx_data,
  output logic         rx_valid
);

  localparam int BIT_W = cnt_width(N);
  localparam int DIV_W = cnt_width(DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (!params_legal(N, DIV)) begin : g_param_check
    $error("shift_frame_ctrl: requires N >= 2 and DIV >= 1");
  end

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic [N-1:0]     rx_data_q, rx_data_d;
  logic             load;
  logic             shift_en;
  logic [N-1:0]     shreg;

  shift_reg_core #(.N(N)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (tx_data),
    .shift_en  (shift_en),
    .si        (si),
    .shreg     (shreg),
    .so        (so)
  );

  assign tx_ready = (state_q == IDLE);
  assign frame    = (state_q == SHIFT);
  // During the completion cycle the register already holds the full received word,
  // so it is forwarded directly; afterwards the captured copy is held.
  assign rx_data  = rx_valid ? shreg : rx_data_q;

  // Next-state, counter and strobe logic; abort overrides strobe and completion.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    divcnt_d  = divcnt_q;
    rx_data_d = rx_data_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    shift_stb = 1'b0;
    rx_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          load     = 1'b1;
          bitcnt_d = '0;
          divcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (divcnt_q == DIV_LAST) begin
          shift_stb = 1'b1;
          shift_en  = 1'b1;
          divcnt_d  = '0;
          if (bitcnt_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end
        end else begin
          divcnt_d = divcnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort) begin
          rx_valid  = 1'b1;
          rx_data_d = shreg;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, counters and received-word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      divcnt_q  <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      divcnt_q  <= divcnt_d;
      rx_data_q <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench for shift_frame_ctrl with N=4 at DIV=1 and DIV=3.
module tb_shift_frame_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         abort;
  logic         si;
  int           sel;

  logic         tx_valid1, tx_valid3;
  logic         r1_ready, r1_so, r1_stb, r1_frame, r1_rxv;
  logic [N-1:0] r1_rxd;
  logic         r3_ready, r3_so, r3_stb, r3_frame, r3_rxv;
  logic [N-1:0] r3_rxd;

  logic         o_ready, o_so, o_stb, o_frame, o_rxv;
  logic [N-1:0] o_rxd;

  int           total = 0;
  int           bad   = 0;
  logic [N-1:0] model_rx [2];

  always #5 clk = ~clk;

  assign tx_valid1 = (sel == 0) ? tx_valid : 1'b0;
  assign tx_valid3 = (sel == 1) ? tx_valid : 1'b0;

  shift_frame_ctrl #(.N(N), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_ready(r1_ready), .abort(abort), .si(si), .so(r1_so),
    .shift_stb(r1_stb), .frame(r1_frame), .rx_data(r1_rxd), .rx_valid(r1_rxv)
  );

  shift_frame_ctrl #(.N(N), .DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid3),
    .tx_ready(r3_ready), .abort(abort), .si(si), .so(r3_so),
    .shift_stb(r3_stb), .frame(r3_frame), .rx_data(r3_rxd), .rx_valid(r3_rxv)
  );

  always_comb begin
    o_ready = r1_ready; o_so = r1_so; o_stb = r1_stb;
    o_frame = r1_frame; o_rxv = r1_rxv; o_rxd = r1_rxd;
    if (sel == 1) begin
      o_ready = r3_ready; o_so = r3_so; o_stb = r3_stb;
      o_frame = r3_frame; o_rxv = r3_rxv; o_rxd = r3_rxd;
    end
  end

  typedef struct {
    logic         tx_valid;
    logic [N-1:0] tx_data;
    logic         si;
    logic         abort;
    logic         ready;
    logic         so;
    logic         stb;
    logic         frame;
    logic         rxv;
    logic [N-1:0] rxd;
  } vec_t;

  vec_t tbl [7];

  function automatic int cur_div();
    return (sel == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (DIV=%0d, t=%0t)", name, act, exp, cur_div(), $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".frame"}, 32'(o_frame), 32'd0);
    chk({tag, ".stb"},   32'(o_stb),   32'd0);
    chk({tag, ".rxv"},   32'(o_rxv),   32'd0);
    chk({tag, ".rxd"},   32'(o_rxd),   32'(model_rx[sel]));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_valid = 1'b0;
      abort    = 1'($urandom);
      si       = 1'($urandom);
      #1;
      check_idle("idle");
    end
  endtask

  // One frame from acceptance to completion (or abort), checked against the frame rules:
  // so shows tx bit k for DIV cycles, rx word = si bits in sampling order.
  // busy_mode: 0 no valid while busy, 1 single valid pulse, 2 valid held with busy_data.
  task automatic run_frame(input logic [N-1:0] tx, input logic [N-1:0] sib, input int abort_cyc,
                           input int busy_mode, input logic [N-1:0] busy_data);
    int div;
    int last;
    int k;
    bit strobe;
    div  = cur_div();
    last = N * div;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = tx; si = 1'b0; abort = 1'b0;
    #1;
    chk("acc.ready", 32'(o_ready), 32'd1);
    chk("acc.frame", 32'(o_frame), 32'd0);
    chk("acc.rxv",   32'(o_rxv),   32'd0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      k        = (c - 1) / div;
      strobe   = (((c - 1) % div) == (div - 1));
      tx_valid = (busy_mode == 2) || (busy_mode == 1 && c == 2);
      tx_data  = busy_data;
      si       = sib[k];
      abort    = (c == abort_cyc);
      #1;
      chk("shift.so",    32'(o_so),    32'(tx[k]));
      chk("shift.frame", 32'(o_frame), 32'd1);
      chk("shift.ready", 32'(o_ready), 32'd0);
      chk("shift.stb",   32'(o_stb),   32'(strobe && !abort));
      chk("shift.rxv",   32'(o_rxv),   32'd0);
      chk("shift.rxd",   32'(o_rxd),   32'(model_rx[sel]));
      if (abort) begin
        @(negedge clk);
        tx_valid = 1'b0; abort = 1'b0; si = 1'b0;
        #1;
        check_idle("post_abort");
        chk("post_abort.so", 32'(o_so), 32'(tx[k]));
        return;
      end
    end
    @(negedge clk);
    tx_valid = (busy_mode == 2);
    tx_data  = busy_data;
    si       = 1'b0;
    abort    = (abort_cyc == last + 1);
    #1;
    chk("done.ready", 32'(o_ready), 32'd0);
    chk("done.frame", 32'(o_frame), 32'd0);
    chk("done.stb",   32'(o_stb),   32'd0);
    chk("done.so",    32'(o_so),    32'(sib[0]));
    if (abort) begin
      chk("done_abort.rxv", 32'(o_rxv), 32'd0);
      chk("done_abort.rxd", 32'(o_rxd), 32'(model_rx[sel]));
      @(negedge clk);
      tx_valid = 1'b0; abort = 1'b0;
      #1;
      check_idle("post_done_abort");
      return;
    end
    chk("done.rxv", 32'(o_rxv), 32'd1);
    chk("done.rxd", 32'(o_rxd), 32'(sib));
    model_rx[sel] = sib;
  endtask

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; abort = 1'b0; si = 1'b0; sel = 0;
    model_rx[0] = '0; model_rx[1] = '0;

    // Reset values on both configurations.
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_idle("reset");
      chk("reset.so", 32'(o_so), 32'd0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, DIV=1: tx 1011, si 1,0,0,1.
    tbl[0] = '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[2] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[3] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[4] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[5] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001};
    tbl[6] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tx_valid = tbl[i].tx_valid; tx_data = tbl[i].tx_data;
      si = tbl[i].si; abort = tbl[i].abort;
      #1;
      chk($sformatf("tbl%0d.ready", i), 32'(o_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d.so", i),    32'(o_so),    32'(tbl[i].so));
      chk($sformatf("tbl%0d.stb", i),   32'(o_stb),   32'(tbl[i].stb));
      chk($sformatf("tbl%0d.frame", i), 32'(o_frame), 32'(tbl[i].frame));
      chk($sformatf("tbl%0d.rxv", i),   32'(o_rxv),   32'(tbl[i].rxv));
      chk($sformatf("tbl%0d.rxd", i),   32'(o_rxd),   32'(tbl[i].rxd));
    end
    model_rx[0] = 4'b1001;

    // Back-to-back with valid held: 5 then C.
    run_frame(4'h5, 4'b0110, -1, 2, 4'hC);
    run_frame(4'hC, 4'b1010, -1, 0, 4'h0);
    idle(1);

    // Abort on the second strobe keeps the previous word 9.
    run_frame(4'h3, 4'b1001, -1, 0, 4'h0);
    run_frame(4'h6, 4'b0111, 2, 0, 4'h0);
    chk("abort.rxd_keep", 32'(o_rxd), 32'h9);

    // Valid pulsed while shifting is ignored.
    run_frame(4'h6, 4'b1100, -1, 1, 4'hF);
    idle(2);

    // Reset asserted mid-frame.
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 4'hD;
    @(negedge clk);
    tx_valid = 1'b0; si = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_rx[0] = '0; model_rx[1] = '0;
    check_idle("midrst");
    chk("midrst.so", 32'(o_so), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(4'h9, 4'b0101, -1, 0, 4'h0);
    idle(1);

    // Divider: DIV=3, tx A.
    sel = 1;
    idle(1);
    run_frame(4'hA, 4'b0011, -1, 0, 4'h0);
    idle(1);

    // Randomized frames on both configurations.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      idle(2);
      for (int f = 0; f < 15; f++) begin
        logic [N-1:0] tx, sib, bd;
        int ab, bm;
        tx = 4'($urandom);
        sib = 4'($urandom);
        bd = 4'($urandom);
        ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N * cur_div() + 1)) : -1;
        bm = int'($urandom_range(0, 2));
        run_frame(tx, sib, ab, bm, bd);
        idle(int'($urandom_range(0, 2)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_frame_ctrl.md
Name: shift_frame_ctrl

Overview:
Controller that sequences an N-bit right-shift register as a full-duplex serial frame engine. It accepts a parallel transmit word over a valid/ready handshake and loads it into the register. It then shifts the word out LSB-first on so, one bit every DIV clocks, while shifting si in at the MSB. At end of frame it presents the captured receive word with a one-cycle valid pulse. It sits between a parallel producer/consumer and a serial pin pair.

Parameters:
N, 4, shift register / frame width in bits (N >= 2)
DIV, 1, clocks per bit period (DIV >= 1); the shift strobe fires every DIV clocks

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
tx_data  in  N  parallel word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  high only in IDLE; transfer occurs when tx_valid && tx_ready
abort  in  1  synchronous frame abort
si  in  1  serial input, sampled on the shift strobe edge
so  out  1  serial output = shreg[0]
shift_stb  out  1  one-cycle pulse on the cycle a shift is committed
frame  out  1  high while in SHIFT
rx_data  out  N  last completed received word, held until the next completion
rx_valid  out  1  one-cycle pulse when rx_data updates

Behaviour:
- Reset (rst_n low, async): state = IDLE, shreg = 0, bitcnt = 0, divcnt = 0, rx_data = 0, rx_valid = 0. Outputs: so = 0, tx_ready = 1, frame = 0, shift_stb = 0.
- FSM states: IDLE, SHIFT, DONE. tx_ready = (state == IDLE). frame = (state == SHIFT). Both are combinational from state.
- IDLE: on tx_valid && tx_ready, load shreg <= tx_data, clear bitcnt and divcnt, go to SHIFT. Otherwise hold; shreg is unchanged and so keeps its last value.
- SHIFT: divcnt counts 0..DIV-1. When divcnt == DIV-1, shift_stb = 1 in the same cycle. At that clock edge:
  - shreg <= {si, shreg[N-1:1]}
  - divcnt <= 0
  - bitcnt <= bitcnt + 1
- SHIFT exit: if bitcnt == N-1 at the strobe, go to DONE instead of incrementing.
- so therefore shows tx bit k for DIV cycles, starting the cycle after acceptance (k = 0..N-1).
- DONE (exactly one cycle): rx_data <= shreg, rx_valid = 1 (registered pulse visible the following cycle is not allowed; rx_valid is asserted in the cycle rx_data becomes valid), go to IDLE. tx_ready = 0 in DONE.
- Frame time: accept-to-rx_valid = N*DIV + 1 cycles. Back-to-back period = N*DIV + 2 cycles.
- Received bit order: the first si bit sampled ends in rx_data[0] and the last in rx_data[N-1].
- abort: in SHIFT or DONE, abort forces IDLE next cycle.
  - No rx_valid; rx_data is unchanged.
  - shreg keeps its partial contents.
  - abort in IDLE has no effect. abort has priority over a strobe or DONE completion in the same cycle.
- tx_valid in non-IDLE states is ignored (no queueing); the producer must hold it until tx_ready.
- Counter widths: bitcnt = clog2(N); divcnt = clog2(DIV), minimum 1 bit. When DIV = 1 every SHIFT cycle is a strobe.
- Reset asserted mid-frame: immediate return to reset values; no partial rx_valid.

Decomposition:
- Package shift_frame_pkg: state enum (IDLE, SHIFT, DONE), clog2-based width constants for bitcnt/divcnt, parameter legality checks (N >= 2, DIV >= 1).
- One sub-module: shift_reg_core, an N-bit register with async active-low reset and two controls:
  - load (parallel tx_data), which has priority
  - shift_en (right shift with serial-in si), which drives so = shreg[0]
- The controller instantiates one shift_reg_core and owns the FSM, counters and rx capture.

Test Plan:
- Reset mid-frame: N=4, DIV=1, assert rst_n low during SHIFT -> all outputs at reset values asynchronously; next accept works normally.
- Basic frame: N=4, DIV=1, tx_data=4'b1011, si sequence 1,0,0,1 on the four strobes -> so = 1,1,0,1 in cycles 1..4 after accept; shift_stb high in those 4 cycles; rx_valid pulses in cycle 5 with rx_data=4'b1001; tx_ready returns in cycle 6.
- Divider: N=4, DIV=3, tx_data=4'hA -> each so bit held 3 cycles (0,1,0,1); shift_stb every 3rd cycle; rx_valid at cycle 13 after accept.
- Back-to-back: tx_valid held high with 4'h5 then 4'hC -> second accept exactly 6 cycles after the first (DIV=1); tx_ready low in SHIFT and DONE; words are not corrupted.
- Abort: abort asserted on the 2nd strobe cycle -> IDLE next cycle, no rx_valid, rx_data keeps its previous value (e.g. 4'h9), tx_ready = 1.
- Ignored valid: pulse tx_valid with 4'hF while in SHIFT -> no effect on the current frame's so sequence or on bitcnt.
